// File: rtl/riscv_fwd_unit.sv
// rtl/riscv_fwd_unit.sv - operand forwarding and load-use hazard control for the 5-stage pipeline
//
// Tracks destination metadata of in-flight instructions in EX, MEM and WB
// slots and selects the EX operand source for rs1/rs2:
//   00 register file, 01 MEM-stage result, 10 WB-stage result.
// Raises a load-use stall toward fetch/decode and counts stall cycles.
//
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_fwd_id_*             instruction currently in ID (valid, rs1/rs2 + enables, rd, we, ld)
//   i_fwd_flush            taken branch/jump in EX; instruction entering EX is killed
//   i_fwd_hold             global freeze; all slots keep their value
//   o_fwd_sel_a/b          operand mux selects for the instruction in EX
//   o_fwd_stall            load-use stall (hold PC and IF/ID, bubble into EX)
//   o_fwd_stall_cnt        saturating stall-cycle counter

module riscv_fwd_unit #(
  parameter int RAW  = 5,
  parameter int CNTW = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_fwd_id_valid,
  input  logic [RAW-1:0]  i_fwd_id_rs1,
  input  logic [RAW-1:0]  i_fwd_id_rs2,
  input  logic            i_fwd_id_rs1_en,
  input  logic            i_fwd_id_rs2_en,
  input  logic [RAW-1:0]  i_fwd_id_rd,
  input  logic            i_fwd_id_we,
  input  logic            i_fwd_id_ld,
  input  logic            i_fwd_flush,
  input  logic            i_fwd_hold,
  output logic [1:0]      o_fwd_sel_a,
  output logic [1:0]      o_fwd_sel_b,
  output logic            o_fwd_stall,
  output logic [CNTW-1:0] o_fwd_stall_cnt
);

  // EX slot
  logic           ex_valid, ex_we, ex_ld, ex_rs1_en, ex_rs2_en;
  logic [RAW-1:0] ex_rd, ex_rs1, ex_rs2;
  // MEM and WB slots; the load flag only matters while in EX (load-use
  // detection), so it is not carried further down the pipe.
  logic           mem_valid, mem_we;
  logic [RAW-1:0] mem_rd;
  logic           wb_valid, wb_we;
  logic [RAW-1:0] wb_rd;

  logic           ex_wr, mem_wr, wb_wr;
  logic           rs1_hit, rs2_hit;
  logic           stall_raw;
  logic           ex_kill;
  logic [CNTW-1:0] cnt_q;

  // x0 is hard-wired zero: a write to it is never a writer.
  assign ex_wr  = ex_valid  & ex_we  & (ex_rd  != '0);
  assign mem_wr = mem_valid & mem_we & (mem_rd != '0);
  assign wb_wr  = wb_valid  & wb_we  & (wb_rd  != '0);

  // MEM is checked first: it holds the youngest value of the register.
  function automatic logic [1:0] pick_src(
    input logic           used,
    input logic [RAW-1:0] rs,
    input logic           mem_w,
    input logic [RAW-1:0] mem_r,
    input logic           wb_w,
    input logic [RAW-1:0] wb_r
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && mem_w && (mem_r == rs)) begin
      sel = 2'b01;
    end else if (used && wb_w && (wb_r == rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    o_fwd_sel_a = pick_src(ex_valid & ex_rs1_en, ex_rs1, mem_wr, mem_rd, wb_wr, wb_rd);
    o_fwd_sel_b = pick_src(ex_valid & ex_rs2_en, ex_rs2, mem_wr, mem_rd, wb_wr, wb_rd);
  end

  // Load result is only available after MEM, so a consumer directly behind a
  // load must wait one cycle and then picks the value up from WB.
  assign rs1_hit   = i_fwd_id_rs1_en & (i_fwd_id_rs1 == ex_rd);
  assign rs2_hit   = i_fwd_id_rs2_en & (i_fwd_id_rs2 == ex_rd);
  assign stall_raw = i_fwd_id_valid & ex_wr & ex_ld & (rs1_hit | rs2_hit);

  // Flush kills the consumer anyway; hold freezes everything, so neither
  // reports a stall.
  assign o_fwd_stall = stall_raw & ~i_fwd_flush & ~i_fwd_hold;
  assign ex_kill     = i_fwd_flush | o_fwd_stall | ~i_fwd_id_valid;

  assign o_fwd_stall_cnt = cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ex_valid  <= 1'b0;
      ex_we     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_rd     <= '0;
      ex_rs1    <= '0;
      ex_rs1_en <= 1'b0;
      ex_rs2    <= '0;
      ex_rs2_en <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      cnt_q     <= '0;
    end else if (!i_fwd_hold) begin
      wb_valid  <= mem_valid;
      wb_we     <= mem_we;
      wb_rd     <= mem_rd;
      mem_valid <= ex_valid;
      mem_we    <= ex_we;
      mem_rd    <= ex_rd;
      if (ex_kill) begin
        ex_valid  <= 1'b0;
        ex_we     <= 1'b0;
        ex_ld     <= 1'b0;
        ex_rd     <= '0;
        ex_rs1    <= '0;
        ex_rs1_en <= 1'b0;
        ex_rs2    <= '0;
        ex_rs2_en <= 1'b0;
      end else begin
        ex_valid  <= 1'b1;
        ex_we     <= i_fwd_id_we;
        ex_ld     <= i_fwd_id_ld;
        ex_rd     <= i_fwd_id_rd;
        ex_rs1    <= i_fwd_id_rs1;
        ex_rs1_en <= i_fwd_id_rs1_en;
        ex_rs2    <= i_fwd_id_rs2;
        ex_rs2_en <= i_fwd_id_rs2_en;
      end
      if (o_fwd_stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_fwd_unit.sv
// tb/tb_riscv_fwd_unit.sv - directed table-driven bench for riscv_fwd_unit

module tb_riscv_fwd_unit;

  localparam int RAW  = 5;
  localparam int CNTW = 4;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [RAW-1:0]  id_rs1, id_rs2, id_rd;
  logic            id_rs1_en, id_rs2_en, id_we, id_ld;
  logic            flush, hold;
  logic [1:0]      sel_a, sel_b;
  logic            stall;
  logic [CNTW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  riscv_fwd_unit #(.RAW(RAW), .CNTW(CNTW)) dut (
    .i_clk           (clk),
    .i_rstn          (rst_n),
    .i_fwd_id_valid  (id_valid),
    .i_fwd_id_rs1    (id_rs1),
    .i_fwd_id_rs2    (id_rs2),
    .i_fwd_id_rs1_en (id_rs1_en),
    .i_fwd_id_rs2_en (id_rs2_en),
    .i_fwd_id_rd     (id_rd),
    .i_fwd_id_we     (id_we),
    .i_fwd_id_ld     (id_ld),
    .i_fwd_flush     (flush),
    .i_fwd_hold      (hold),
    .o_fwd_sel_a     (sel_a),
    .o_fwd_sel_b     (sel_b),
    .o_fwd_stall     (stall),
    .o_fwd_stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           v;
    logic [RAW-1:0] rs1;
    logic           e1;
    logic [RAW-1:0] rs2;
    logic           e2;
    logic [RAW-1:0] rd;
    logic           we;
    logic           ld;
    logic           fl;
    logic [1:0]     ea;
    logic [1:0]     eb;
    logic           es;
    logic [CNTW-1:0] ec;
  } vec_t;

  vec_t tbl [33];

  function automatic vec_t mk(logic v, logic [RAW-1:0] rs1, logic e1, logic [RAW-1:0] rs2,
                              logic e2, logic [RAW-1:0] rd, logic we, logic ld, logic fl,
                              logic [1:0] ea, logic [1:0] eb, logic es, logic [CNTW-1:0] ec);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.e1 = e1; r.rs2 = rs2; r.e2 = e2; r.rd = rd;
    r.we = we; r.ld = ld; r.fl = fl; r.ea = ea; r.eb = eb; r.es = es; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [RAW-1:0] rs1, input logic e1,
                       input logic [RAW-1:0] rs2, input logic e2, input logic [RAW-1:0] rd,
                       input logic we, input logic ld, input logic fl, input logic hd);
    id_valid = v; id_rs1 = rs1; id_rs1_en = e1; id_rs2 = rs2; id_rs2_en = e2;
    id_rd = rd; id_we = we; id_ld = ld; flush = fl; hold = hd;
  endtask

  // Inputs change 1 after the rising edge, outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string nm, input logic [1:0] ea, input logic [1:0] eb,
                           input logic es, input logic [CNTW-1:0] ec);
    chk({nm, ".sel_a"}, 32'(sel_a), 32'(ea));
    chk({nm, ".sel_b"}, 32'(sel_b), 32'(eb));
    chk({nm, ".stall"}, 32'(stall), 32'(es));
    chk({nm, ".cnt"},   32'(stall_cnt), 32'(ec));
  endtask

  initial begin
    int exp_cnt;

    // columns: v rs1 e1 rs2 e2 rd we ld fl | sel_a sel_b stall cnt
    tbl[0]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);  // writer x5
    tbl[1]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reader x5
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);  // reader in EX: MEM fwd
    tbl[3]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);  // writer x5
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reader x5 after 1 gap
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);  // WB fwd
    tbl[7]  = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0);  // writer x6
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reader x6 after 2 gaps
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // regfile
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);  // writer x0
    tbl[13] = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // reader x0,x0
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // no fwd for x0
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);  // load x0
    tbl[16] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // reader x0: no stall
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);  // writer x7
    tbl[19] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);  // writer x7
    tbl[20] = mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // reader rs2=x7
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  // MEM beats WB
    tbl[22] = mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0);  // load x3
    tbl[23] = mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0);  // dependent: stall
    tbl[24] = mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1);  // re-presented, bubble in EX
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);  // consumer gets WB
    tbl[26] = mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1);  // load x3
    tbl[27] = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // rs2_en=0: no stall
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // not forwarded either
    tbl[29] = mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1);  // load x3
    tbl[30] = mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);  // dependent + flush
    tbl[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  // EX is a bubble
    tbl[32] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset state, observed before any clock edge.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_out("reset", 2'b00, 2'b00, 1'b0, '0);
    next_cycle();
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].e1, tbl[i].rs2, tbl[i].e2,
            tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].fl, 1'b0);
      #4;
      check_out($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].es, tbl[i].ec);
      next_cycle();
    end

    // Hold for 3 cycles with writer x9 in MEM and a load-use pending in ID.
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);  // writer x9
    #4; check_out("h0", 0, 0, 0, 1); next_cycle();
    drive(1, 9, 1, 0, 0, 4, 1, 1, 0, 0);  // load x4 reading x9
    #4; check_out("h1", 0, 0, 0, 1); next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 1);  // reader x4, frozen
      #4; check_out($sformatf("hold%0d", k), 1, 0, 0, 1); next_cycle();
    end
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);  // hold released: stall now shows
    #4; check_out("h5", 1, 0, 1, 1); next_cycle();
    #4; check_out("h6", 0, 0, 0, 2); next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #4; check_out("h7", 2, 0, 0, 2); next_cycle();

    // Repeated load-use stalls drive the 4-bit counter into saturation.
    exp_cnt = 2;
    for (int k = 0; k < 15; k++) begin
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      #4; chk($sformatf("sat%0d.a_stall", k), 32'(stall), 0); next_cycle();
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      #4; chk($sformatf("sat%0d.b_stall", k), 32'(stall), 1); next_cycle();
      if (exp_cnt < 15) exp_cnt++;
      #4; chk($sformatf("sat%0d.cnt", k), 32'(stall_cnt), 32'(exp_cnt)); next_cycle();
    end

    // Async reset in the middle of a forward + stall.
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);  // writer x10
    #4; next_cycle();
    drive(1, 10, 1, 0, 0, 8, 1, 1, 0, 0);  // load x8 reading x10
    #4; next_cycle();
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);   // reader x8
    #4; check_out("pre_rst", 1, 0, 1, 15);
    #1 rst_n = 1'b0;
    #1; check_out("mid_rst", 0, 0, 0, 0);
    next_cycle();
    #4 rst_n = 1'b1;
    next_cycle();
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);   // first instruction after release
    #4; check_out("post_rst0", 0, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #4; check_out("post_rst1", 0, 0, 0, 0); next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
